// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding decode. Holds the PC and issues word reads
//   to instruction memory. Returned words go into a small FIFO together with
//   the address they were fetched from. Decode sees {opcode, pc} over a
//   valid/ready handshake. A redirect flushes the FIFO and discards every
//   response still in flight; the stage then restarts at the new PC.
//
// Parameters
//   N         PC / address width
//   RESET_PC  PC after reset (bits [1:0] forced to 0)
//   DEPTH     FIFO entries and max outstanding requests (power of 2, >= 2)
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   mem_req_valid/ready/addr        word read request to instruction memory
//   mem_rsp_valid/data              in-order read data, one per accepted request
//   redirect_valid/redirect_pc      branch/jump target; flushes the stage
//   out_valid/out_ready             handshake towards decode
//   out_opcode/out_pc               FIFO head: instruction word and its address
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_fetched  saturating count of instructions accepted by decode
//   perf_flushed  saturating count of FIFO entries + in-flight responses
//                 discarded by redirects
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [N-1:0]  mem_req_addr,
    input  logic          mem_rsp_valid,
    input  logic [31:0]   mem_rsp_data,
    input  logic          redirect_valid,
    input  logic [N-1:0]  redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_opcode,
    output logic [N-1:0]  out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);

    localparam int           AW      = $clog2(DEPTH);
    localparam int           CW      = AW + 1;
    localparam logic [CW:0]  DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [N-1:0] ALIGN   = ~N'(3);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fifo_count_q, fifo_count_d;
    logic [AW-1:0]   fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [AW-1:0]   aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
    // Holds off requests for the first cycle after reset so that
    // mem_req_valid reads 0 both during and right out of reset.
    logic            running_q;

    // Instruction FIFO plus the side queue of request addresses; the side
    // queue advances on every response, kept or discarded, so it always
    // lines up with the in-order response stream.
    logic [31:0]     fifo_op_mem [DEPTH];
    logic [N-1:0]    fifo_pc_mem [DEPTH];
    logic [N-1:0]    aq_mem      [DEPTH];

    logic [CW:0]     inflight_total;
    logic            req_accept;
    logic            out_accept;
    logic            push;
    logic            pop;
    logic [CW-1:0]   rsp_dec;

    assign inflight_total = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign mem_req_valid  = running_q && (state_q == RUN) && !redirect_valid
                            && (inflight_total < DEPTH_L);
    assign mem_req_addr   = pc_q;
    assign req_accept     = mem_req_valid && mem_req_ready;

    assign out_valid      = (fifo_count_q != '0);
    assign out_opcode     = out_valid ? fifo_op_mem[fifo_rd_q] : '0;
    assign out_pc         = out_valid ? fifo_pc_mem[fifo_rd_q] : '0;
    // A same-cycle out_ready during a redirect still accepts the head; the
    // flush then empties the FIFO anyway.
    assign out_accept     = out_valid && out_ready;
    assign pop            = out_accept && !redirect_valid;
    assign push           = mem_rsp_valid && (state_q == RUN) && !redirect_valid;
    assign rsp_dec        = CW'(mem_rsp_valid);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        fifo_count_d  = fifo_count_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        aq_rd_d       = aq_rd_q;
        aq_wr_d       = aq_wr_q;
        outstanding_d = outstanding_q + CW'(req_accept) - rsp_dec;

        if (req_accept) begin
            pc_d    = pc_q + N'(4);
            aq_wr_d = aq_wr_q + AW'(1);
        end
        if (mem_rsp_valid) begin
            aq_rd_d = aq_rd_q + AW'(1);
        end

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    fifo_count_d = '0;
                    fifo_rd_d    = '0;
                    fifo_wr_d    = '0;
                    pc_d         = redirect_pc & ALIGN;
                    // The response arriving now is already discarded.
                    drop_d       = outstanding_q - rsp_dec;
                    state_d      = (drop_d != '0) ? DRAIN : RUN;
                end else begin
                    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
                    fifo_wr_d    = fifo_wr_q + AW'(push);
                    fifo_rd_d    = fifo_rd_q + AW'(pop);
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc & ALIGN;
                end
                drop_d  = drop_q - rsp_dec;
                state_d = (drop_d == '0) ? RUN : DRAIN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC & ALIGN;
            outstanding_q <= '0;
            drop_q        <= '0;
            fifo_count_q  <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            aq_rd_q       <= '0;
            aq_wr_q       <= '0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fifo_count_q  <= fifo_count_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            aq_rd_q       <= aq_rd_d;
            aq_wr_q       <= aq_wr_d;
            running_q     <= 1'b1;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_mem[fifo_wr_q] <= mem_rsp_data;
            fifo_pc_mem[fifo_wr_q] <= aq_mem[aq_rd_q];
        end
        if (req_accept) begin
            aq_mem[aq_wr_q] <= pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] flush_amt;
    logic [32:0] flush_sum;

    // Entries thrown away by a redirect from RUN: FIFO contents other than
    // a head accepted in the same cycle, plus every response in flight.
    assign flush_amt = 32'(fifo_count_q) + 32'(outstanding_q) - 32'(out_accept);
    assign flush_sum = {1'b0, perf_flushed_q} + {1'b0, flush_amt};

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (out_accept && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect_valid && (state_q == RUN)) begin
            perf_flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

    // A response with nothing outstanding means the memory broke protocol.
    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst) mem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A memory model answers accepted requests
//   in order after a programmable latency; a scoreboard of expected
//   {pc, opcode} pairs is filled as requests are accepted (address predicted
//   by the bench's own PC model) and drained when decode accepts an output.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_opcode;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.N(32), .RESET_PC(RPC), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] sb_pc[$];
    logic [31:0] sb_op[$];
    logic [31:0] acc_pcs[$];
    int          n_req = 0;
    int          drain_pending = 0;
    int          drain_viol = 0;
    int          gaps = 0;
    int          first_req_cyc = -1;
    int          first_out_cyc = -1;
    int          mark = 0;
    logic        obs_out_valid;
    logic        obs_req_valid;
    logic        obs_rsp;
    logic        wrap_seen = 1'b0;
    logic [31:0] prev_req_addr = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int idx);
        if (idx < acc_pcs.size()) return acc_pcs[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive the memory response, sample outputs before the
    // edge, update the models, then advance to the next falling edge.
    task automatic cycle();
        logic [31:0] e_pc, e_op;
        logic        rspv;
        rspv = 1'b0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memfn(pend_addr.pop_front());
            void'(pend_due.pop_front());
            rspv = 1'b1;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
        #1;
        obs_out_valid = out_valid;
        obs_req_valid = mem_req_valid;
        obs_rsp       = rspv;
        if (drain_pending > 0 && mem_req_valid) drain_viol++;
        if (redirect_valid) check("req_blocked_on_redirect", 32'(mem_req_valid), 32'h0);
        if (out_valid && out_ready) begin
            if (sb_pc.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'h0);
            end else begin
                e_pc = sb_pc.pop_front();
                e_op = sb_op.pop_front();
                check("out_pc", out_pc, e_pc);
                check("out_opcode", out_opcode, e_op);
            end
            acc_pcs.push_back(out_pc);
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (mem_req_valid && mem_req_ready) begin
            check("req_addr", mem_req_addr, exp_pc);
            if (prev_req_addr == 32'hFFFF_FFFC) begin
                check("pc_wrap", mem_req_addr, 32'h0);
                wrap_seen = 1'b1;
            end
            prev_req_addr = mem_req_addr;
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            sb_pc.push_back(exp_pc);
            sb_op.push_back(memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (redirect_valid) begin
            sb_pc.delete();
            sb_op.delete();
            exp_pc        = redirect_pc & ~32'h3;
            drain_pending = pend_addr.size();
        end else if (rspv && drain_pending > 0) begin
            drain_pending--;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        pend_addr.delete();
        pend_due.delete();
        sb_pc.delete();
        sb_op.delete();
        acc_pcs.delete();
        drain_pending = 0;
        exp_pc        = RPC;
        prev_req_addr = 32'h0;
        first_req_cyc = -1;
        first_out_cyc = -1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        exp_pc         = RPC;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_out_opcode", out_opcode, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_req_addr", mem_req_addr, RPC);

        // 1: streaming with 1-cycle memory
        do_reset();
        lat = 1;
        repeat (6) cycle();
        check("t1_fetch_latency", 32'(first_out_cyc - first_req_cyc), 32'd2);
        check("t1_first_pc", acc_at(0), RPC);
        gaps = 0;
        repeat (10) begin
            cycle();
            if (!obs_out_valid) gaps++;
        end
        check("t1_gaps", 32'(gaps), 32'h0);

        // 2: decode stalled for 20 cycles
        do_reset();
        out_ready = 1'b0;
        n_req = 0;
        repeat (20) cycle();
        check("t2_requests", 32'(n_req), 32'd4);
        check("t2_req_valid", 32'(obs_req_valid), 32'h0);
        check("t2_out_valid", 32'(out_valid), 32'h1);
        check("t2_head_pc", out_pc, RPC);
        check("t2_head_op", out_opcode, memfn(RPC));
        out_ready = 1'b1;
        mark = acc_pcs.size();
        gaps = 0;
        repeat (12) begin
            cycle();
            if (!obs_out_valid) gaps++;
        end
        check("t2_gaps", 32'(gaps), 32'h0);
        check("t2_resume_pc", acc_at(mark), RPC);

        // 3: redirect with 3 requests in flight, 5-cycle latency
        do_reset();
        lat = 5;
        n_req = 0;
        for (int i = 0; i < 20 && n_req < 3; i++) cycle();
        check("t3_in_flight", 32'(n_req), 32'd3);
        drain_viol = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        cycle();
        redirect_valid = 1'b0;
        check("t3_discard_count", 32'(drain_pending), 32'd3);
        mark = acc_pcs.size();
        for (int i = 0; i < 30 && drain_pending > 0; i++) cycle();
        check("t3_drained", 32'(drain_pending), 32'h0);
        check("t3_no_req_in_drain", 32'(drain_viol), 32'h0);
        for (int i = 0; i < 40 && acc_pcs.size() == mark; i++) cycle();
        check("t3_first_pc", acc_at(mark), 32'h0000_2000);

        // 4: redirect coinciding with a response and a decode accept
        lat = 1;
        repeat (12) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        mark = acc_pcs.size();
        cycle();
        redirect_valid = 1'b0;
        check("t4_out_valid_at_redirect", 32'(obs_out_valid), 32'h1);
        check("t4_rsp_at_redirect", 32'(obs_rsp), 32'h1);
        check("t4_head_accepted", 32'(acc_pcs.size()), 32'(mark + 1));
        cycle();
        check("t4_empty_next", 32'(obs_out_valid), 32'h0);
        repeat (8) cycle();
        check("t4_first_pc", acc_at(mark + 1), 32'h0000_4000);

        // 5: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF9;
        cycle();
        redirect_valid = 1'b0;
        mark = acc_pcs.size();
        repeat (10) cycle();
        check("t5_wrap_seen", 32'(wrap_seen), 32'h1);
        check("t5_first_pc", acc_at(mark), 32'hFFFF_FFF8);
        check("t5_wrapped_pc", acc_at(mark + 2), 32'h0000_0000);

        // 6: asynchronous reset with the FIFO full
        out_ready = 1'b0;
        repeat (10) cycle();
        check("t6_full_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'h0);
        check("t6_rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("t6_rst_pc", mem_req_addr, RPC);
`ifdef FETCH_PERF_EN
        check("t6_rst_perf_fetched", perf_fetched, 32'h0);
        check("t6_rst_perf_flushed", perf_flushed, 32'h0);
`endif
        do_reset();
        out_ready = 1'b1;
        repeat (8) cycle();
        check("t6_restart_pc", acc_at(0), RPC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
